// File: rtl/objective.sv
`default_nettype none
// ============================================================================
// Module   : objective
// Purpose  : Training-loop error stage. Joins the associate unit's forward
//            result stream with a target stream, applies a step activation
//            to the result and returns the saturated signed error
//            (target - activation) on a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1     rising-edge clock
//   reset_n    in   1     synchronous active-low reset
//   res_valid  in   1     forward result valid
//   res_ready  out  1     result accepted on res_valid & res_ready
//   res_data   in   RESW  forward result (signed)
//   tgt_valid  in   1     target valid
//   tgt_ready  out  1     target accepted on tgt_valid & tgt_ready
//   tgt_data   in   RESW  target (signed)
//   err_valid  out  1     error valid
//   err_ready  in   1     error consumed on err_valid & err_ready
//   err_data   out  ERRW  saturated signed error
//   clear      in   1     zero the statistics counters   (OBJECTIVE_STATS_EN)
//   total      out  CNTW  delivered-error count          (OBJECTIVE_STATS_EN)
//   miss       out  CNTW  delivered non-zero error count (OBJECTIVE_STATS_EN)
// Configuration macro: OBJECTIVE_STATS_EN adds clear/total/miss and CNTW.
// ============================================================================
module objective #(
  parameter int                       RESW   = 16,
  parameter int                       ERRW   = 16,
  parameter logic        [RESW-1:0]   HIGH   = RESW'(16'h00ff),
  parameter logic        [RESW-1:0]   LOW    = '0,
  parameter logic signed [RESW-1:0]   THRESH = '0
`ifdef OBJECTIVE_STATS_EN
  ,
  parameter int                       CNTW   = 16
`endif
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [RESW-1:0] res_data,
  input  logic            tgt_valid,
  output logic            tgt_ready,
  input  logic [RESW-1:0] tgt_data,
  output logic            err_valid,
  input  logic            err_ready,
  output logic [ERRW-1:0] err_data
`ifdef OBJECTIVE_STATS_EN
  ,
  input  logic            clear,
  output logic [CNTW-1:0] total,
  output logic [CNTW-1:0] miss
`endif
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [RESW-1:0] r_res;
  logic [RESW-1:0] r_tgt;
  logic            r_res_held;
  logic            r_tgt_held;
  logic [ERRW-1:0] r_err_data;
  logic            w_res_take;
  logic            w_tgt_take;
  logic [RESW-1:0] w_act;
  logic [RESW:0]   w_diff;
  logic [ERRW-1:0] w_err_sat;

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    res_ready    = 1'b0;
    tgt_ready    = 1'b0;
    err_valid    = 1'b0;
    w_res_take   = 1'b0;
    w_tgt_take   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        res_ready  = !r_res_held;
        tgt_ready  = !r_tgt_held;
        w_res_take = res_valid && !r_res_held;
        w_tgt_take = tgt_valid && !r_tgt_held;
        // Move on as soon as both operands will be held after this edge.
        if ((r_res_held || w_res_take) && (r_tgt_held || w_tgt_take)) begin
          w_state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        err_valid = 1'b1;
        if (err_ready) begin
          w_state_next = ST_COLLECT;
        end
      end
      default: begin
        w_state_next = ST_COLLECT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Step activation and error at one guard bit above the operand width
  // --------------------------------------------------------------------------
  assign w_act  = ($signed(r_res) < THRESH) ? LOW : HIGH;
  assign w_diff = {r_tgt[RESW-1], r_tgt} - {w_act[RESW-1], w_act};

  generate
    if (ERRW > RESW) begin : g_sat_wide
      // Error port wide enough for every difference: plain sign extension.
      assign w_err_sat = ERRW'($signed(w_diff));
    end else begin : g_sat_narrow
      logic w_ovf;
      // Overflow when the bits above the error sign bit disagree with it.
      assign w_ovf     = !((&w_diff[RESW:ERRW-1]) || !(|w_diff[RESW:ERRW-1]));
      assign w_err_sat = w_ovf ? (w_diff[RESW] ? {1'b1, {(ERRW-1){1'b0}}}
                                               : {1'b0, {(ERRW-1){1'b1}}})
                               : w_diff[ERRW-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State, operand and error registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_COLLECT;
      r_res      <= '0;
      r_tgt      <= '0;
      r_res_held <= 1'b0;
      r_tgt_held <= 1'b0;
      r_err_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_res_take) begin
        r_res      <= res_data;
        r_res_held <= 1'b1;
      end
      if (w_tgt_take) begin
        r_tgt      <= tgt_data;
        r_tgt_held <= 1'b1;
      end
      if (r_state == ST_COMPUTE) begin
        r_err_data <= w_err_sat;
        r_res_held <= 1'b0;
        r_tgt_held <= 1'b0;
      end
    end
  end

  assign err_data = r_err_data;

`ifdef OBJECTIVE_STATS_EN
  // --------------------------------------------------------------------------
  // Delivery statistics; saturating, clear wins over a same-cycle increment
  // --------------------------------------------------------------------------
  logic [CNTW-1:0] r_total;
  logic [CNTW-1:0] r_miss;
  logic            w_err_hs;

  assign w_err_hs = (r_state == ST_SEND) && err_ready;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_total <= '0;
      r_miss  <= '0;
    end else if (w_err_hs) begin
      if (!(&r_total)) begin
        r_total <= r_total + CNTW'(1);
      end
      if ((r_err_data != '0) && !(&r_miss)) begin
        r_miss <= r_miss + CNTW'(1);
      end
    end
  end

  assign total = r_total;
  assign miss  = r_miss;
`endif

endmodule
`default_nettype wire
